div_unit: RTL
=============

# div_unit

Iterative 32-bit radix-2 divider serving DIV/DIVU in the EX stage. EX drives start and operands, raises ex_stall_request while the divider is working, and returns quotient/remainder to LO/HI through the existing write_hilo path. One quotient bit is resolved per clock using restoring division on operand magnitudes, with a sign fix-up for signed divides. Divide-by-zero short-circuits; an in-flight divide can be cancelled when the pipeline flushes.

## Interface
- DATA_W, 32, operand/result width (fixed; no other value supported)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level request; sampled only in IDLE
- cancel  in  1  abort in-flight divide; no result is produced
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- dividend  in  32  sampled with accepted start
- divisor  in  32  sampled with accepted start
- busy  out  1  registered; high while iterating
- done  out  1  registered; one-cycle pulse, results valid
- quotient  out  32  result to LO
- remainder  out  32  result to HI
- div_by_zero  out  1  qualifies done; divisor was 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 and cancel=0 accepts the request (start with cancel=1 is ignored).
  - divisor==0 -> DONE with quotient=0, remainder=0, div_by_zero=1.
  - Else latch |dividend| and |divisor| (magnitude only if signed_div and MSB=1; 0x80000000 magnitude is 0x80000000 unsigned), latch neg_q = signed_div & (dividend[31]^divisor[31]) and neg_r = signed_div & dividend[31], clear partial remainder, counter=0 -> RUN.
- RUN, per edge: 33-bit trial = {rem[31:0], dq[31]} - {1'b0, dvs}; if non-negative, rem = trial[31:0] and shift in q bit 1; else rem = {rem[30:0], dq[31]} and shift in 0. Counter increments and wraps 31->0 on the 32nd iteration, which moves to DONE.
- Entering DONE from RUN: quotient = neg_q ? -q : q; remainder = neg_r ? -r : r (32-bit wrap); div_by_zero=0.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally; start in DONE is ignored.
- cancel=1 in RUN: next edge -> IDLE; done stays 0; quotient/remainder/div_by_zero keep their previous values.
- quotient/remainder/div_by_zero hold until the next result is written.
- The requester deasserts start in the done cycle; start still high in the following IDLE cycle begins a new divide.

## Timing
- Reset values: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0. rst overrides everything, including mid-RUN; no done is generated.
- Normal divide, start accepted at the edge ending cycle 0:
  - busy=1 in cycles 1..32.
  - done=1 and results valid in cycle 33; busy=0 in cycle 33.
  - Latency: 33 cycles.
- Divide-by-zero: done=1 in cycle 1; busy never asserts.
- Operand inputs are ignored after acceptance and may change freely.
- EX stall condition = (start & ~done).

## Test plan
- Unsigned 100 / 7: start in cycle 0 -> busy cycles 1..32, done in cycle 33 only, quotient=14, remainder=2.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7 / 0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- Overflow corner, 0x80000000 / 0xFFFFFFFF:
  - signed -> quotient=0x80000000, remainder=0.
  - unsigned -> quotient=0, remainder=0x80000000.
- Divide by zero, 5 / 0 -> done and div_by_zero in cycle 1, quotient=0, remainder=0. A following 9/3 -> quotient=3, div_by_zero=0.
- Cancel:
  - cancel in cycle 10 of 100/7 -> IDLE in cycle 11, no done, outputs keep the previous result.
  - New start in cycle 12 for 9/2 -> done in cycle 45, quotient=4, remainder=1.
- rst in cycle 20 of a divide -> cycle 21 all outputs 0, state IDLE. start/cancel together in IDLE -> no acceptance.

Source files
------------

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative radix-2 restoring divider used by DIV/DIVU in the EX stage.
// One quotient bit is resolved per clock on the operand magnitudes. Signed
// results are corrected afterwards: the quotient is negated when the operand
// signs differ, and the remainder takes the sign of the dividend. A zero
// divisor completes in a single cycle with a zero result and div_by_zero set.
// An in-flight divide can be abandoned with cancel, and no result is produced.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        level request, only looked at while idle
//   cancel       abandon the divide in progress (also blocks a start in IDLE)
//   signed_div   1 = two's complement divide, 0 = unsigned divide
//   dividend     dividend, captured when a start is accepted
//   divisor      divisor, captured when a start is accepted
//   busy         registered, high while iterating
//   done         registered, one-cycle pulse when results are valid
//   quotient     result for LO, held until the next result is written
//   remainder    result for HI, held until the next result is written
//   div_by_zero  qualifies done, set when the divisor was zero
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cancel,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [4:0]        cnt, cnt_nxt;
  logic [DATA_W-1:0] rem, rem_nxt;
  logic [DATA_W-1:0] dq, dq_nxt;
  logic [DATA_W-1:0] dvs, dvs_nxt;
  logic              neg_q, neg_q_nxt;
  logic              neg_r, neg_r_nxt;
  logic              busy_nxt, done_nxt;
  logic [DATA_W-1:0] quotient_nxt, remainder_nxt;
  logic              div_by_zero_nxt;

  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_dq;
  logic [DATA_W-1:0] dividend_mag;
  logic [DATA_W-1:0] divisor_mag;

  // dq starts out holding the dividend magnitude; each step shifts its top
  // bit into the partial remainder and shifts the new quotient bit in at the
  // bottom, so after the last step dq holds the whole quotient.
  // The trial subtraction is one bit wider than the data so its top bit is
  // the borrow: a clear borrow means the divisor fits and the quotient bit
  // is 1.
  always_comb begin
    trial        = {rem, dq[DATA_W-1]} - {1'b0, dvs};
    step_rem     = trial[DATA_W] ? {rem[DATA_W-2:0], dq[DATA_W-1]}
                                 : trial[DATA_W-1:0];
    step_dq      = {dq[DATA_W-2:0], ~trial[DATA_W]};
    // The most negative value negates to itself, which read as unsigned is
    // already the correct magnitude.
    dividend_mag = (signed_div && dividend[DATA_W-1]) ? -dividend : dividend;
    divisor_mag  = (signed_div && divisor[DATA_W-1])  ? -divisor  : divisor;
  end

  // Next-state and next-output logic. Every register holds by default, and
  // busy/done default low so that each one pulses only where it is set below.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    rem_nxt         = rem;
    dq_nxt          = dq;
    dvs_nxt         = dvs;
    neg_q_nxt       = neg_q;
    neg_r_nxt       = neg_r;
    busy_nxt        = 1'b0;
    done_nxt        = 1'b0;
    quotient_nxt    = quotient;
    remainder_nxt   = remainder;
    div_by_zero_nxt = div_by_zero;

    case (state)
      IDLE: begin
        if (start && !cancel) begin
          if (divisor == '0) begin
            state_nxt       = DONE;
            done_nxt        = 1'b1;
            quotient_nxt    = '0;
            remainder_nxt   = '0;
            div_by_zero_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
            busy_nxt  = 1'b1;
            dq_nxt    = dividend_mag;
            dvs_nxt   = divisor_mag;
            rem_nxt   = '0;
            cnt_nxt   = '0;
            neg_q_nxt = signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            neg_r_nxt = signed_div & dividend[DATA_W-1];
          end
        end
      end

      RUN: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else begin
          rem_nxt = step_rem;
          dq_nxt  = step_dq;
          cnt_nxt = cnt + 5'd1;
          // The count wraps back to zero on the last step, so it is already
          // cleared when the next divide starts.
          if (cnt == 5'd31) begin
            state_nxt       = DONE;
            done_nxt        = 1'b1;
            quotient_nxt    = neg_q ? -step_dq  : step_dq;
            remainder_nxt   = neg_r ? -step_rem : step_rem;
            div_by_zero_nxt = 1'b0;
          end else begin
            busy_nxt = 1'b1;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers. Reset wins over everything, including a
  // divide in progress, so no done is produced for an interrupted divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      dq          <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rem         <= rem_nxt;
      dq          <= dq_nxt;
      dvs         <= dvs_nxt;
      neg_q       <= neg_q_nxt;
      neg_r       <= neg_r_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      div_by_zero <= div_by_zero_nxt;
    end
  end

endmodule
